// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM bank: channel record layout,
// its reset value and the prescaler floor.
package pwm_pkg;

  localparam int PRESCALE_MIN = 3;
  localparam int CNT_MAX_W    = 16;

  // Counts are stored at the widest supported counter width and zero-extended.
  typedef struct packed {
    logic [CNT_MAX_W-1:0] on;
    logic [CNT_MAX_W-1:0] off;
    logic                 full_on;
    logic                 full_off;
  } chan_rec_t;

  localparam chan_rec_t CHAN_REC_RST = '{
    on:       '0,
    off:      '0,
    full_on:  1'b0,
    full_off: 1'b1
  };

endpackage

// File: rtl/pwm_compare.sv
// Per-channel level decode: forced levels first, then the on/off window,
// which may straddle the counter wrap when on > off.
module pwm_compare
  import pwm_pkg::*;
#(
  parameter int CNT_W = 12
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  chan_rec_t        rec_i,
  output logic             level_o
);

  logic [CNT_MAX_W-1:0] cnt;

  always_comb begin
    cnt     = CNT_MAX_W'(cnt_i);
    level_o = 1'b0;
    if (rec_i.full_off) begin
      level_o = 1'b0;
    end else if (rec_i.full_on) begin
      level_o = 1'b1;
    end else if (rec_i.on < rec_i.off) begin
      level_o = (cnt >= rec_i.on) && (cnt < rec_i.off);
    end else if (rec_i.on > rec_i.off) begin
      level_o = (cnt >= rec_i.on) || (cnt < rec_i.off);
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one prescaler and period counter,
// with double-buffered channel records committed at wrap or immediately.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter  int NUM_CH = 16,
  parameter  int CNT_W  = 12,
  parameter  int PRE_W  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [PRE_W-1:0]  prescale_i,
  input  logic              sleep_i,
  input  logic              invert_i,
  input  logic              commit_mode_i,
  input  logic              wr_en_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic [CNT_W-1:0]  wr_on_i,
  input  logic [CNT_W-1:0]  wr_off_i,
  input  logic              wr_full_on_i,
  input  logic              wr_full_off_i,
  output logic              wr_ack_o,
  output logic [CNT_W-1:0]  counter_o,
  output logic              period_start_o,
  output logic [NUM_CH-1:0] pwm_o
);

  logic [PRE_W-1:0]  pre_q, pre_d, pre_lim;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_ack_q, wr_ack_d;
  logic              ps_q, ps_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d, level;
  logic              tick, wrap, wr_valid;
  chan_rec_t         wr_rec;
  chan_rec_t [NUM_CH-1:0] pend_q, pend_d, act_q, act_d;

  // Timebase. Using >= lets a shrinking prescale take effect at the next compare.
  always_comb begin
    pre_lim = (prescale_i < PRE_W'(PRESCALE_MIN)) ? PRE_W'(PRESCALE_MIN) : prescale_i;
    tick    = !sleep_i && (pre_q >= pre_lim);
    wrap    = tick && (cnt_q == '1);
    pre_d   = pre_q + 1'b1;
    cnt_d   = cnt_q;
    if (sleep_i) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 1'b1;
    end
    ps_d = wrap;
  end

  // Channel records. A write landing on the wrap edge must win over the bulk copy.
  always_comb begin
    wr_valid = wr_en_i && (int'(wr_ch_i) < NUM_CH);
    wr_ack_d = wr_valid;
    wr_rec   = '{on:       CNT_MAX_W'(wr_on_i),
                 off:      CNT_MAX_W'(wr_off_i),
                 full_on:  wr_full_on_i,
                 full_off: wr_full_off_i};
    pend_d   = pend_q;
    act_d    = act_q;
    if (wrap && !commit_mode_i) act_d = pend_q;
    if (wr_valid) begin
      pend_d[wr_ch_i] = wr_rec;
      if (commit_mode_i || wrap) act_d[wr_ch_i] = wr_rec;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_compare #(.CNT_W(CNT_W)) u_cmp (
      .cnt_i   (cnt_q),
      .rec_i   (act_q[g]),
      .level_o (level[g])
    );
  end

  always_comb pwm_d = level ^ {NUM_CH{invert_i}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      cnt_q    <= '0;
      wr_ack_q <= 1'b0;
      ps_q     <= 1'b0;
      pwm_q    <= '0;
      pend_q   <= {NUM_CH{CHAN_REC_RST}};
      act_q    <= {NUM_CH{CHAN_REC_RST}};
    end else begin
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      wr_ack_q <= wr_ack_d;
      ps_q     <= ps_d;
      pwm_q    <= pwm_d;
      pend_q   <= pend_d;
      act_q    <= act_d;
    end
  end

  assign wr_ack_o       = wr_ack_q;
  assign counter_o      = cnt_q;
  assign period_start_o = ps_q;
  assign pwm_o          = pwm_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed scenarios plus random traffic,
// compared against a behavioural model built from window arithmetic.
module tb_pwm_bank;

  localparam int NUM_CH = 12;
  localparam int CNT_W  = 12;
  localparam int PRE_W  = 8;
  localparam int CH_W   = 4;
  localparam int M      = 4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PRE_W-1:0]  prescale;
  logic              sleep, invert, cmode, wr_en, wr_fon, wr_foff;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_on, wr_off;
  logic              wr_ack_o, period_start_o;
  logic [CNT_W-1:0]  counter_o;
  logic [NUM_CH-1:0] pwm_o;

  always #5 clk = ~clk;

  pwm_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .prescale_i     (prescale),
    .sleep_i        (sleep),
    .invert_i       (invert),
    .commit_mode_i  (cmode),
    .wr_en_i        (wr_en),
    .wr_ch_i        (wr_ch),
    .wr_on_i        (wr_on),
    .wr_off_i       (wr_off),
    .wr_full_on_i   (wr_fon),
    .wr_full_off_i  (wr_foff),
    .wr_ack_o       (wr_ack_o),
    .counter_o      (counter_o),
    .period_start_o (period_start_o),
    .pwm_o          (pwm_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  typedef struct { int on; int off; bit fon; bit foff; } mrec_t;
  mrec_t pend[NUM_CH];
  mrec_t act[NUM_CH];
  int    m_cnt, m_since, m_p;
  bit    m_tick, m_wrap, m_wv;
  logic [NUM_CH-1:0] e_pwm;
  logic  e_ack, e_ps;

  // High when the count lies inside the half-open window [on, off) taken modulo the period.
  function automatic bit lvl(mrec_t r, int c);
    int span, pos;
    if (r.foff) return 1'b0;
    if (r.fon)  return 1'b1;
    span = (((r.off - r.on) % M) + M) % M;
    pos  = (((c - r.on) % M) + M) % M;
    return pos < span;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_since = 0; e_ack = 1'b0; e_ps = 1'b0; e_pwm = '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pend[i] = '{on: 0, off: 0, fon: 1'b0, foff: 1'b1};
        act[i]  = pend[i];
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) e_pwm[i] = lvl(act[i], m_cnt) ^ invert;
      m_p    = (int'(prescale) < 3) ? 3 : int'(prescale);
      m_tick = !sleep && (m_since >= m_p);
      m_wrap = m_tick && (m_cnt == M - 1);
      m_wv   = wr_en && (int'(wr_ch) < NUM_CH);
      e_ack  = m_wv;
      e_ps   = m_wrap;
      if (m_wv) begin
        pend[wr_ch] = '{on: int'(wr_on), off: int'(wr_off), fon: wr_fon, foff: wr_foff};
        if (cmode) act[wr_ch] = pend[wr_ch];
      end
      if (m_wrap && !cmode)
        for (int i = 0; i < NUM_CH; i++) act[i] = pend[i];
      if (sleep) begin
        m_cnt = 0; m_since = 0;
      end else if (m_tick) begin
        m_cnt = (m_cnt + 1) % M; m_since = 0;
      end else begin
        m_since++;
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; prescale = '0; sleep = 1'b0; invert = 1'b0; cmode = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_on = '0; wr_off = '0; wr_fon = 1'b0; wr_foff = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (counter_o !== '0) begin n_bad++; $display("FAIL reset_counter got=%0d exp=0", counter_o); end
    n_cmp++;
    if (pwm_o !== '0) begin n_bad++; $display("FAIL reset_pwm got=%h exp=0", pwm_o); end
    n_cmp++;
    if ({wr_ack_o, period_start_o} !== 2'b00) begin
      n_bad++; $display("FAIL reset_pulses got=%b exp=00", {wr_ack_o, period_start_o});
    end
  endtask

  task automatic test_prescale();
    int ps_seen = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 16386; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== {CNT_W'(m_cnt), e_pwm, e_ack, e_ps}) begin
        n_bad++; $display("FAIL prescale_cyc n=%0d got=%h exp=%h", n,
          {counter_o, pwm_o, wr_ack_o, period_start_o}, {CNT_W'(m_cnt), e_pwm, e_ack, e_ps});
      end
      if (period_start_o) ps_seen++;
      if (n == 4) begin
        n_cmp++;
        if (counter_o !== 12'd1) begin n_bad++; $display("FAIL first_tick got=%0d exp=1", counter_o); end
      end
      if (n == 16383) begin
        n_cmp++;
        if (counter_o !== 12'd4095) begin n_bad++; $display("FAIL pre_wrap got=%0d exp=4095", counter_o); end
      end
      if (n == 16384) begin
        n_cmp++;
        if ({counter_o, period_start_o} !== {12'd0, 1'b1}) begin
          n_bad++; $display("FAIL wrap got cnt=%0d ps=%b exp cnt=0 ps=1", counter_o, period_start_o);
        end
      end
    end
    n_cmp++;
    if (ps_seen !== 1) begin n_bad++; $display("FAIL ps_count got=%0d exp=1", ps_seen); end
    n_cmp++;
    if (pwm_o !== '0) begin n_bad++; $display("FAIL idle_pwm got=%h exp=0", pwm_o); end
  endtask

  task automatic test_mode0();
    int hi3 = 0, hi7 = 0;
    cmode = 1'b0;
    sleep = 1'b1; @(negedge clk); sleep = 1'b0;
    for (int n = 1; n <= 32768; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== {CNT_W'(m_cnt), e_pwm, e_ack, e_ps}) begin
        n_bad++; $display("FAIL mode0_cyc n=%0d got=%h exp=%h", n,
          {counter_o, pwm_o, wr_ack_o, period_start_o}, {CNT_W'(m_cnt), e_pwm, e_ack, e_ps});
      end
      if (n <= 16384) begin
        n_cmp++;
        if (pwm_o[3] !== 1'b0) begin n_bad++; $display("FAIL mode0_early n=%0d got=%b exp=0", n, pwm_o[3]); end
      end else begin
        hi3 += int'(pwm_o[3]);
        hi7 += int'(pwm_o[7]);
      end
      if (n == 2001) begin
        n_cmp++;
        if (wr_ack_o !== 1'b1) begin n_bad++; $display("FAIL mode0_ack got=%b exp=1", wr_ack_o); end
      end
      wr_en = 1'b0;
      if (n == 2000) begin
        wr_en = 1'b1; wr_ch = 4'd3; wr_on = 12'd100; wr_off = 12'd300; wr_fon = 1'b0; wr_foff = 1'b0;
      end
      if (n == 16383) begin
        wr_en = 1'b1; wr_ch = 4'd7; wr_on = 12'd0; wr_off = 12'd2048; wr_fon = 1'b0; wr_foff = 1'b0;
      end
    end
    n_cmp++;
    if (hi3 !== 800) begin n_bad++; $display("FAIL mode0_ch3_high got=%0d exp=800", hi3); end
    n_cmp++;
    if (hi7 !== 8192) begin n_bad++; $display("FAIL wrap_write_ch7_high got=%0d exp=8192", hi7); end
  endtask

  task automatic test_mode1();
    int hi0 = 0;
    cmode = 1'b1; sleep = 1'b1;
    wr_en = 1'b1; wr_ch = 4'd0; wr_on = 12'd4000; wr_off = 12'd96; wr_fon = 1'b0; wr_foff = 1'b0;
    @(negedge clk);
    sleep = 1'b0; wr_en = 1'b0;
    for (int n = 1; n <= 16384; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== {CNT_W'(m_cnt), e_pwm, e_ack, e_ps}) begin
        n_bad++; $display("FAIL mode1_cyc n=%0d got=%h exp=%h", n,
          {counter_o, pwm_o, wr_ack_o, period_start_o}, {CNT_W'(m_cnt), e_pwm, e_ack, e_ps});
      end
      hi0 += int'(pwm_o[0]);
    end
    n_cmp++;
    if (hi0 !== 768) begin n_bad++; $display("FAIL mode1_ch0_high got=%0d exp=768", hi0); end
  endtask

  task automatic test_full_invert();
    cmode = 1'b1;
    wr_en = 1'b1; wr_ch = 4'd5; wr_on = 12'd10; wr_off = 12'd20; wr_fon = 1'b1; wr_foff = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pwm_o[5] !== 1'b0) begin n_bad++; $display("FAIL full_prio got=%b exp=0", pwm_o[5]); end
    invert = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (pwm_o[5] !== 1'b1) begin n_bad++; $display("FAIL invert got=%b exp=1", pwm_o[5]); end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== {CNT_W'(m_cnt), e_pwm, e_ack, e_ps}) begin
        n_bad++; $display("FAIL invert_cyc n=%0d got=%h exp=%h", n,
          {counter_o, pwm_o, wr_ack_o, period_start_o}, {CNT_W'(m_cnt), e_pwm, e_ack, e_ps});
      end
    end
    invert = 1'b0;
  endtask

  task automatic test_sleep_badwrite();
    repeat (100) @(negedge clk);
    sleep = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, period_start_o} !== {12'd0, 1'b0}) begin
        n_bad++; $display("FAIL sleep_hold n=%0d got cnt=%0d ps=%b exp cnt=0 ps=0", n, counter_o, period_start_o);
      end
    end
    sleep = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== {CNT_W'(m_cnt), e_pwm, e_ack, e_ps}) begin
        n_bad++; $display("FAIL wake_cyc n=%0d got=%h exp=%h", n,
          {counter_o, pwm_o, wr_ack_o, period_start_o}, {CNT_W'(m_cnt), e_pwm, e_ack, e_ps});
      end
      if (n == 4) begin
        n_cmp++;
        if (counter_o !== 12'd1) begin n_bad++; $display("FAIL wake_first_tick got=%0d exp=1", counter_o); end
      end
      wr_en = 1'b0;
      if (n == 10 || n == 20) begin
        wr_en = 1'b1; wr_ch = (n == 10) ? 4'd12 : 4'd15;
        wr_on = 12'd1; wr_off = 12'd2; wr_fon = 1'b1; wr_foff = 1'b0;
      end
      if (n == 11 || n == 21) begin
        n_cmp++;
        if (wr_ack_o !== 1'b0) begin n_bad++; $display("FAIL bad_ch_ack n=%0d got=%b exp=0", n, wr_ack_o); end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== {CNT_W'(m_cnt), e_pwm, e_ack, e_ps}) begin
        n_bad++; $display("FAIL rand_cyc n=%0d got=%h exp=%h", n,
          {counter_o, pwm_o, wr_ack_o, period_start_o}, {CNT_W'(m_cnt), e_pwm, e_ack, e_ps});
      end
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_ch   = CH_W'($urandom_range(0, 15));
      wr_on   = CNT_W'($urandom_range(0, 4095));
      wr_off  = CNT_W'($urandom_range(0, 4095));
      wr_fon  = ($urandom_range(0, 7) == 0);
      wr_foff = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0)  cmode  = ~cmode;
      if ($urandom_range(0, 127) == 0) invert = ~invert;
      if ($urandom_range(0, 199) == 0) prescale = PRE_W'($urandom_range(0, 9));
      sleep = ($urandom_range(0, 299) == 0);
    end
    wr_en = 1'b0; sleep = 1'b0;
  endtask

  task automatic test_reset_midrun();
    wr_en = 1'b1; wr_ch = 4'd2; wr_on = 12'd0; wr_off = 12'd50; wr_fon = 1'b0; wr_foff = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== '0) begin
      n_bad++; $display("FAIL async_reset got=%h exp=0", {counter_o, pwm_o, wr_ack_o, period_start_o});
    end
    @(negedge clk);
    wr_en = 1'b0; prescale = 8'd5; invert = 1'b0; cmode = 1'b1; rst_n = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      n_cmp++;
      if ({counter_o, pwm_o, wr_ack_o, period_start_o} !== {CNT_W'(m_cnt), e_pwm, e_ack, e_ps}) begin
        n_bad++; $display("FAIL rst_cyc n=%0d got=%h exp=%h", n,
          {counter_o, pwm_o, wr_ack_o, period_start_o}, {CNT_W'(m_cnt), e_pwm, e_ack, e_ps});
      end
      if (n == 5 || n == 6) begin
        n_cmp++;
        if (counter_o !== CNT_W'(n - 5)) begin
          n_bad++; $display("FAIL rst_first_tick n=%0d got=%0d exp=%0d", n, counter_o, n - 5);
        end
      end
      n_cmp++;
      if (pwm_o !== '0) begin n_bad++; $display("FAIL rst_records n=%0d got=%h exp=0", n, pwm_o); end
    end
  endtask

  initial begin
    test_reset();
    test_prescale();
    test_mode0();
    test_mode1();
    test_full_invert();
    test_sleep_badwrite();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
